// File: rtl/seg_decoder.sv
// Seven-segment pattern decoder feeding a small show-ahead FIFO of {err, code} entries,
// with a saturating count of unrecognised patterns.
module seg_decoder #(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [6:0]               seg_in,
    input  logic                     seg_valid,
    output logic                     seg_ready,
    output logic [2:0]               code_out,
    output logic                     code_err,
    output logic                     code_valid,
    input  logic                     code_ready,
    input  logic                     err_clr,
    output logic [CW-1:0]            err_count,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             FW      = AW + 1;
    localparam logic [FW-1:0]  LP_FULL = FW'(DEPTH);

    // Returns {err, code}; bit order of seg is abcdefg with a in bit 6.
    function automatic logic [3:0] decode(input logic [6:0] seg);
        logic [3:0] r;
        case (seg)
            7'b0111110: r = 4'b0000;
            7'b0000110: r = 4'b0001;
            7'b1100111: r = 4'b0010;
            7'b1000111: r = 4'b0011;
            7'b1001111: r = 4'b0100;
            7'b0001000: r = 4'b0101;
            7'b1000000: r = 4'b0110;
            default:    r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [FW-1:0] r_fill;
    logic [CW-1:0] r_err_cnt;
    logic          r_rdy_en;

    logic [3:0]    w_dec;
    logic [3:0]    w_head;
    logic          w_wr;
    logic          w_rd;

    assign w_dec      = decode(seg_in);
    assign w_head     = r_mem[r_rd_ptr];
    // r_rdy_en keeps seg_ready low until the first edge after reset release.
    assign seg_ready  = r_rdy_en && (r_fill != LP_FULL);
    assign code_valid = (r_fill != '0);
    assign w_wr       = seg_valid && seg_ready;
    assign w_rd       = code_valid && code_ready;

    assign code_out   = code_valid ? w_head[2:0] : 3'b000;
    assign code_err   = code_valid ? w_head[3]   : 1'b0;
    assign err_count  = r_err_cnt;
    assign fill       = r_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en  <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fill    <= '0;
            r_err_cnt <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_fill <= r_fill + FW'(1);
                2'b01:   r_fill <= r_fill - FW'(1);
                default: r_fill <= r_fill;
            endcase
            if (err_clr) begin
                r_err_cnt <= '0;
            end else if (w_wr && w_dec[3]) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end
        end
    end

    // Storage is not reset: stale entries are unreachable once fill is cleared.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

endmodule
